// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared CPU definitions: bus widths, arbiter state encoding and
//           the default fetch-starvation limit.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Bus widths of the CPU core
  localparam int CPU_DATA_WIDTH = 32;
  localparam int CPU_ADDR_WIDTH = 32;

  // Consecutive data grants tolerated while an instruction fetch waits
  localparam int ARB_STARVE_LIMIT = 4;

  // Memory arbiter states
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DATA   = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-master arbiter sharing one external memory port between the
//           instruction fetch stage and the memory (load/store) stage. Data
//           accesses win by default; a saturating counter forces a fetch
//           grant once data has been served STARVE_LIMIT times in a row while
//           fetch was waiting. A fetch flushed in flight still completes on
//           the bus but its result is dropped.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH   = CPU_ADDR_WIDTH,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_done,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // memory-stage port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_done,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // external memory port
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  arb_state_e              state_q,     state_d;
  logic [CNT_WIDTH-1:0]    starve_q,    starve_d;
  logic                    discard_q,   discard_d;
  logic                    mem_req_q,   mem_req_d;
  logic                    mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]     mem_be_q,    mem_be_d;
  logic                    if_done_q,   if_done_d;
  logic                    d_done_q,    d_done_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q,   d_rdata_d;

  logic fetch_ok;
  logic starve_hit;
  logic grant_fetch;

  // A flushed fetch request is never granted; fetch wins only when data is
  // absent or data has already had its full run of grants.
  assign fetch_ok    = if_req && !if_flush;
  assign starve_hit  = (starve_q == CNT_LIMIT);
  assign grant_fetch = fetch_ok && (!d_req || starve_hit);

  // Next-state, grant and response logic
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        // Nobody is waiting for fetch, so nobody is being starved
        if (!if_req) begin
          starve_d = '0;
        end
        if (grant_fetch) begin
          state_d     = ARB_IFETCH;
          starve_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end else if (d_req) begin
          state_d     = ARB_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_we ? d_be : {BE_WIDTH{1'b1}};
          // Saturate so a flushed-but-held fetch cannot wrap the count
          if (if_req && !starve_hit) begin
            starve_d = starve_q + CNT_WIDTH'(1);
          end
        end
      end

      ARB_IFETCH: begin
        if (if_flush) begin
          discard_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          // A flush in the ack cycle itself also kills the response
          if (!(discard_q || if_flush)) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      ARB_DATA: begin
        if (mem_ack) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end

      ARB_RESP: begin
        // No grant here: a requester dropping req on its done pulse is safe
        state_d   = ARB_IDLE;
        discard_d = 1'b0;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter. Directed scenarios followed
//           by a randomized phase, all checked against a transaction-level
//           reference model of the arbitration policy and bus protocol.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef enum int {P_IDLE, P_WAIT, P_RESP} phase_t;
  phase_t      ph = P_IDLE;
  int          who = 0;          // 0 none, 1 fetch, 2 data
  int          streak = 0;       // data grants in a row while fetch waited
  int          lat_left = 0;     // extra mem_req cycles before ack
  bit          discard = 1'b0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  logic [31:0] g_addr = '0, g_wdata = '0, g_rdata = '0;
  logic        g_we = 1'b0;
  logic [3:0]  g_be = '0;

  // ---------------- stimulus controls ----------------
  int          fix_lat = -1;
  bit          fix_rd_en = 1'b0;
  logic [31:0] fix_rd = '0;
  bit          f_auto = 1'b0, d_auto = 1'b0, d_hold = 1'b0;

  int          grant_log[$];
  logic [3:0]  be_log[$];
  int          n_ifdone = 0, n_ddone = 0;
  int          n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int be_at(input int i);
    return (i < be_log.size()) ? int'(be_log[i]) : -1;
  endfunction

  task automatic chk_fields(input string tag);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(g_addr));
    chk({tag, "_mem_we"},   64'(mem_we),   64'(g_we));
    chk({tag, "_mem_be"},   64'(mem_be),   64'(g_be));
    if (who == 2) chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(g_wdata));
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // compare DUT outputs, then drive memory and requester inputs.
  task automatic step();
    logic        s_rst   = rst;
    logic        s_ifr   = if_req;
    logic        s_fl    = if_flush;
    logic        s_fe    = if_req && !if_flush;
    logic        s_dreq  = d_req;
    logic        s_dwe   = d_we;
    logic [31:0] s_ifa   = if_addr;
    logic [31:0] s_da    = d_addr;
    logic [31:0] s_dwd   = d_wdata;
    logic [3:0]  s_dbe   = d_be;
    logic        s_ack   = mem_ack;
    logic [31:0] s_rdata = mem_rdata;
    @(posedge clk);
    #1;
    if (s_rst) begin
      ph = P_IDLE; who = 0; streak = 0; discard = 1'b0; lat_left = 0;
      exp_if_rdata = '0; exp_d_rdata = '0;
      chk("rst_mem_req",   64'(mem_req),   64'(0));
      chk("rst_mem_we",    64'(mem_we),    64'(0));
      chk("rst_mem_addr",  64'(mem_addr),  64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_mem_be",    64'(mem_be),    64'(0));
      chk("rst_if_done",   64'(if_done),   64'(0));
      chk("rst_d_done",    64'(d_done),    64'(0));
    end else begin
      case (ph)
        P_IDLE: begin
          if (s_dreq || s_fe) begin
            if (s_fe && (!s_dreq || streak == LIMIT)) begin
              who = 1; g_addr = s_ifa; g_we = 1'b0; g_be = 4'hF; streak = 0;
            end else begin
              who = 2; g_addr = s_da; g_we = s_dwe; g_wdata = s_dwd;
              g_be = s_dwe ? s_dbe : 4'hF;
              if (s_ifr && streak < LIMIT) streak++;
            end
            grant_log.push_back(who);
            be_log.push_back(g_be);
            lat_left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
            g_rdata  = fix_rd_en ? fix_rd : $urandom;
            discard  = 1'b0;
            ph = P_WAIT;
            chk("grant_mem_req", 64'(mem_req), 64'(1));
            chk_fields("grant");
          end else begin
            if (!s_ifr) streak = 0;
            chk("idle_mem_req", 64'(mem_req), 64'(0));
          end
          chk("idle_if_done", 64'(if_done), 64'(0));
          chk("idle_d_done",  64'(d_done),  64'(0));
        end
        P_WAIT: begin
          if (who == 1 && s_fl) discard = 1'b1;
          if (s_ack) begin
            ph = P_RESP;
            if (who == 1 && !discard) exp_if_rdata = s_rdata;
            if (who == 2) exp_d_rdata = s_rdata;
            chk("resp_if_done", 64'(if_done), 64'(who == 1 && !discard));
            chk("resp_d_done",  64'(d_done),  64'(who == 2));
            chk("resp_mem_req", 64'(mem_req), 64'(0));
          end else begin
            chk("wait_mem_req", 64'(mem_req), 64'(1));
            chk_fields("wait");
            chk("wait_if_done", 64'(if_done), 64'(0));
            chk("wait_d_done",  64'(d_done),  64'(0));
          end
        end
        default: begin
          ph = P_IDLE; discard = 1'b0;
          chk("post_mem_req", 64'(mem_req), 64'(0));
          chk("post_if_done", 64'(if_done), 64'(0));
          chk("post_d_done",  64'(d_done),  64'(0));
        end
      endcase
    end
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("d_rdata",  64'(d_rdata),  64'(exp_d_rdata));
    if (if_done) n_ifdone++;
    if (d_done)  n_ddone++;

    // memory responder
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (ph == P_WAIT) begin
      if (lat_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = g_rdata;
      end else begin
        lat_left--;
      end
    end

    // requesters drop on their done pulse, optionally re-raise at random
    if (if_done) if_req = 1'b0;
    if (d_done && !d_hold) d_req = 1'b0;
    if (f_auto && !if_req && $urandom_range(0, 3) == 0) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_auto && !d_req && $urandom_range(0, 2) == 0) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      d_be    = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_if, b_d, steps;
    int exp_seq[7];
    exp_seq = '{2, 2, 2, 2, 1, 2, 2};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    repeat (2) step();

    // single fetch, ack two cycles after mem_req rises
    fix_lat = 2; fix_rd_en = 1'b1; fix_rd = 32'h2402_000A;
    grant_log.delete(); be_log.delete();
    b_if = n_ifdone; steps = 0;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    for (int k = 0; k < 20 && n_ifdone == b_if; k++) begin step(); steps++; end
    chk("t1_if_done_count", 64'(n_ifdone), 64'(b_if + 1));
    chk("t1_if_rdata",      64'(if_rdata), 64'(32'h2402_000A));
    chk("t1_grant_fetch",   64'(log_at(0)), 64'(1));
    chk("t1_latency",       64'(steps),    64'(4));
    fix_rd_en = 1'b0;
    repeat (2) step();

    // contention: data write first, then the pending fetch
    fix_lat = -1;
    grant_log.delete(); be_log.delete();
    b_if = n_ifdone; b_d = n_ddone;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    for (int k = 0; k < 40 && (n_ifdone == b_if || n_ddone == b_d); k++) step();
    repeat (5) step();
    chk("t2_d_done_count",  64'(n_ddone - b_d),    64'(1));
    chk("t2_if_done_count", 64'(n_ifdone - b_if),  64'(1));
    chk("t2_grant_count",   64'(grant_log.size()), 64'(2));
    chk("t2_first_data",    64'(log_at(0)), 64'(2));
    chk("t2_first_be",      64'(be_at(0)),  64'(4'b0011));
    chk("t2_second_fetch",  64'(log_at(1)), 64'(1));

    // starvation: data held for six requests while fetch waits
    grant_log.delete(); be_log.delete();
    b_d = n_ddone;
    d_hold = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h400;
    for (int k = 0; k < 200 && n_ddone < b_d + 6; k++) step();
    d_hold = 1'b0; d_req = 1'b0;
    repeat (4) step();
    chk("t3_grant_count", 64'(grant_log.size()), 64'(7));
    for (int i = 0; i < 7; i++) chk($sformatf("t3_grant_%0d", i), 64'(log_at(i)), 64'(exp_seq[i]));

    // flush while the fetch is on the bus
    fix_lat = 2;
    grant_log.delete(); be_log.delete();
    b_if = n_ifdone;
    if_req = 1'b1; if_addr = 32'h80;
    step(); step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    repeat (5) step();
    chk("t4_no_if_done",   64'(n_ifdone), 64'(b_if));
    chk("t4_bus_tx_count", 64'(grant_log.size()), 64'(1));
    fix_lat = 1;
    if_req = 1'b1; if_addr = 32'hC0;
    for (int k = 0; k < 20 && n_ifdone == b_if; k++) step();
    chk("t4_refetch_done", 64'(n_ifdone), 64'(b_if + 1));
    repeat (2) step();

    // reset in the middle of a data read, stray ack afterwards
    fix_lat = 10;
    b_d = n_ddone;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step(); step();
    rst = 1'b1; d_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    repeat (3) step();
    chk("t5_no_d_done", 64'(n_ddone), 64'(b_d));
    chk("t5_mem_req",   64'(mem_req), 64'(0));

    // randomized traffic from both requesters
    fix_lat = -1;
    f_auto = 1'b1; d_auto = 1'b1;
    repeat (500) step();
    f_auto = 1'b0; d_auto = 1'b0;
    for (int k = 0; k < 60 && (if_req || d_req || ph != P_IDLE); k++) step();
    chk("t6_drained", 64'(ph == P_IDLE && !if_req && !d_req), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
